// File: rtl/decode_stage.sv
// ARM-style decode stage with ID/EX pipeline register.
// LDM/STM are expanded into one memory uop per listed register by a two-state sequencer.
module decode_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_in,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] if_id_instruction,
   input  logic [ADDR_WIDTH-1:0] if_id_pc,
   input  logic [ADDR_WIDTH-1:0] if_id_pc_plus_4,
   output logic                  id_stall_out,
   output logic [3:0]            rf_ra1,
   output logic [3:0]            rf_ra2,
   input  logic [DATA_WIDTH-1:0] rf_rd1,
   input  logic [DATA_WIDTH-1:0] rf_rd2,
   output logic                  id_ex_valid,
   output logic [3:0]            id_ex_cond,
   output logic [1:0]            id_ex_class,
   output logic [3:0]            id_ex_opcode,
   output logic                  id_ex_set_flags,
   output logic [DATA_WIDTH-1:0] id_ex_rn_val,
   output logic [DATA_WIDTH-1:0] id_ex_op2_val,
   output logic [1:0]            id_ex_shift_type,
   output logic [4:0]            id_ex_shift_amt,
   output logic [3:0]            id_ex_rd,
   output logic                  id_ex_is_load,
   output logic                  id_ex_is_store,
   output logic                  id_ex_wb_base,
   output logic [DATA_WIDTH-1:0] id_ex_wb_val,
   output logic [ADDR_WIDTH-1:0] id_ex_branch_target,
   output logic [ADDR_WIDTH-1:0] id_ex_pc
);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SEQ   = 1'b1;
   localparam logic [1:0] CLS_DP  = 2'd0;
   localparam logic [1:0] CLS_MEM = 2'd1;
   localparam logic [1:0] CLS_BR  = 2'd2;
   localparam logic [1:0] CLS_BLK = 2'd3;

   typedef struct packed {
      logic                  valid;
      logic [3:0]            cond;
      logic [1:0]            cls;
      logic [3:0]            opcode;
      logic                  set_flags;
      logic [DATA_WIDTH-1:0] rn_val;
      logic [DATA_WIDTH-1:0] op2_val;
      logic [1:0]            shift_type;
      logic [4:0]            shift_amt;
      logic [3:0]            rd;
      logic                  is_load;
      logic                  is_store;
      logic                  wb_base;
      logic [DATA_WIDTH-1:0] wb_val;
      logic [ADDR_WIDTH-1:0] branch_target;
      logic [ADDR_WIDTH-1:0] pc;
   } id_ex_t;

   id_ex_t                id_ex_reg, id_ex_next;
   logic [0:0]            state_reg, state_next;
   logic [15:0]           rem_reg;
   logic [DATA_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] wbv_reg;
   logic                  load_reg;
   logic                  wb_reg;
   logic                  seq_stall;

   logic [31:0] ins;
   assign ins    = if_id_instruction[31:0];
   assign rf_ra1 = ins[19:16];

   // Rotating the doubled byte makes the wrap-around fall out of a plain slice.
   logic [4:0]  rot_amt;
   logic [63:0] imm_dbl;
   logic [31:0] imm_rot;
   assign rot_amt = {ins[11:8], 1'b0};
   assign imm_dbl = {24'd0, ins[7:0], 24'd0, ins[7:0]};
   assign imm_rot = imm_dbl[rot_amt +: 32];

   logic [ADDR_WIDTH-1:0] br_target;
   assign br_target = if_id_pc + ADDR_WIDTH'(8)
                    + {{(ADDR_WIDTH-26){ins[23]}}, ins[23:0], 2'b00};

   logic [4:0]            blk_n;
   logic [DATA_WIDTH-1:0] blk_n4, blk_start, blk_wbv;
   always_comb begin
      blk_n = '0;
      for (int i = 0; i < 16; i++) blk_n = blk_n + {4'd0, ins[i]};
   end
   assign blk_n4 = DATA_WIDTH'({blk_n, 2'b00});

   always_comb begin
      case ({ins[24], ins[23]})
         2'b01:   blk_start = rf_rd1;
         2'b11:   blk_start = rf_rd1 + DATA_WIDTH'(4);
         2'b00:   blk_start = rf_rd1 - blk_n4 + DATA_WIDTH'(4);
         default: blk_start = rf_rd1 - blk_n4;
      endcase
   end
   assign blk_wbv = ins[23] ? (rf_rd1 + blk_n4) : (rf_rd1 - blk_n4);

   // The list being worked on: fresh from IF/ID when idle, the remainder mid-sequence.
   logic [15:0] act_list, lo_onehot, rest_list;
   logic [3:0]  lo_idx;
   logic        act_last;
   assign act_list = (state_reg == S_SEQ) ? rem_reg : ins[15:0];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_lowest
         if (gi == 0) begin : g_first
            assign lo_onehot[gi] = act_list[0];
         end else begin : g_rest
            assign lo_onehot[gi] = act_list[gi] & ~(|act_list[gi-1:0]);
         end
      end
   endgenerate

   always_comb begin
      lo_idx = '0;
      for (int i = 0; i < 16; i++)
         if (lo_onehot[i]) lo_idx = lo_idx | 4'(i);
   end
   assign rest_list = act_list & ~lo_onehot;
   assign act_last  = (rest_list == 16'd0);

   always_comb begin
      id_ex_next               = '0;
      id_ex_next.cond          = ins[31:28];
      id_ex_next.rn_val        = rf_rd1;
      id_ex_next.op2_val       = rf_rd2;
      id_ex_next.rd            = ins[15:12];
      id_ex_next.pc            = if_id_pc;
      id_ex_next.branch_target = br_target;
      rf_ra2                   = ins[3:0];
      state_next               = state_reg;
      seq_stall                = 1'b0;
      if (state_reg == S_SEQ) begin
         id_ex_next.valid    = 1'b1;
         id_ex_next.cls      = CLS_BLK;
         id_ex_next.rn_val   = addr_reg;
         id_ex_next.rd       = lo_idx;
         id_ex_next.is_load  = load_reg;
         id_ex_next.is_store = ~load_reg;
         id_ex_next.wb_base  = wb_reg & act_last;
         id_ex_next.wb_val   = (wb_reg & act_last) ? wbv_reg : '0;
         rf_ra2              = lo_idx;
         seq_stall           = ~act_last;
         if (act_last) state_next = S_IDLE;
      end else if (ins[31:28] != 4'hF) begin
         casez (ins[27:25])
            3'b00?: begin
               id_ex_next.valid     = 1'b1;
               id_ex_next.cls       = CLS_DP;
               id_ex_next.opcode    = ins[24:21];
               id_ex_next.set_flags = ins[20];
               if (ins[25]) begin
                  id_ex_next.op2_val = DATA_WIDTH'(imm_rot);
               end else begin
                  id_ex_next.shift_type = ins[6:5];
                  id_ex_next.shift_amt  = ins[11:7];
               end
            end
            3'b01?: begin
               id_ex_next.valid    = 1'b1;
               id_ex_next.cls      = CLS_MEM;
               id_ex_next.is_load  = ins[20];
               id_ex_next.is_store = ~ins[20];
               if (!ins[25]) id_ex_next.op2_val = DATA_WIDTH'(ins[11:0]);
            end
            3'b101: begin
               id_ex_next.valid = 1'b1;
               id_ex_next.cls   = CLS_BR;
               if (ins[24]) begin
                  id_ex_next.rd      = 4'd14;
                  id_ex_next.op2_val = DATA_WIDTH'(if_id_pc_plus_4);
               end
            end
            3'b100: begin
               if (act_list != 16'd0) begin
                  id_ex_next.valid    = 1'b1;
                  id_ex_next.cls      = CLS_BLK;
                  id_ex_next.rn_val   = blk_start;
                  id_ex_next.rd       = lo_idx;
                  id_ex_next.is_load  = ins[20];
                  id_ex_next.is_store = ~ins[20];
                  rf_ra2              = lo_idx;
                  if (act_last) begin
                     id_ex_next.wb_base = ins[21];
                     id_ex_next.wb_val  = ins[21] ? blk_wbv : '0;
                  end else begin
                     seq_stall  = 1'b1;
                     state_next = S_SEQ;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      if (rst || flush)  id_stall_out = 1'b0;
      else if (stall_in) id_stall_out = 1'b1;
      else               id_stall_out = seq_stall;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_reg <= '0;
         state_reg <= S_IDLE;
         rem_reg   <= '0;
         addr_reg  <= '0;
         wbv_reg   <= '0;
         load_reg  <= 1'b0;
         wb_reg    <= 1'b0;
      end else if (flush) begin
         id_ex_reg.valid    <= 1'b0;
         id_ex_reg.is_load  <= 1'b0;
         id_ex_reg.is_store <= 1'b0;
         id_ex_reg.wb_base  <= 1'b0;
         state_reg          <= S_IDLE;
      end else if (!stall_in) begin
         id_ex_reg <= id_ex_next;
         state_reg <= state_next;
         if (state_next == S_SEQ) begin
            rem_reg <= rest_list;
            // Base is captured once so later register writes cannot skew the sequence.
            if (state_reg == S_IDLE) begin
               addr_reg <= blk_start + DATA_WIDTH'(4);
               wbv_reg  <= blk_wbv;
               load_reg <= ins[20];
               wb_reg   <= ins[21];
            end else begin
               addr_reg <= addr_reg + DATA_WIDTH'(4);
            end
         end
      end
   end

   assign id_ex_valid         = id_ex_reg.valid;
   assign id_ex_cond          = id_ex_reg.cond;
   assign id_ex_class         = id_ex_reg.cls;
   assign id_ex_opcode        = id_ex_reg.opcode;
   assign id_ex_set_flags     = id_ex_reg.set_flags;
   assign id_ex_rn_val        = id_ex_reg.rn_val;
   assign id_ex_op2_val       = id_ex_reg.op2_val;
   assign id_ex_shift_type    = id_ex_reg.shift_type;
   assign id_ex_shift_amt     = id_ex_reg.shift_amt;
   assign id_ex_rd            = id_ex_reg.rd;
   assign id_ex_is_load       = id_ex_reg.is_load;
   assign id_ex_is_store      = id_ex_reg.is_store;
   assign id_ex_wb_base       = id_ex_reg.wb_base;
   assign id_ex_wb_val        = id_ex_reg.wb_val;
   assign id_ex_branch_target = id_ex_reg.branch_target;
   assign id_ex_pc            = id_ex_reg.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against an instruction-level model.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst, stall_in, flush;
   logic [31:0] if_id_instruction, if_id_pc, if_id_pc_plus_4;
   logic        id_stall_out;
   logic [3:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        id_ex_valid, id_ex_set_flags, id_ex_is_load, id_ex_is_store, id_ex_wb_base;
   logic [3:0]  id_ex_cond, id_ex_opcode, id_ex_rd;
   logic [1:0]  id_ex_class, id_ex_shift_type;
   logic [4:0]  id_ex_shift_amt;
   logic [31:0] id_ex_rn_val, id_ex_op2_val, id_ex_wb_val, id_ex_branch_target, id_ex_pc;

   logic [31:0] regs [16];
   int vectors = 0;
   int miscompares = 0;

   assign rf_rd1 = regs[rf_ra1];
   assign rf_rd2 = regs[rf_ra2];

   always #5 clk = ~clk;

   decode_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
      .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
      .if_id_pc_plus_4(if_id_pc_plus_4), .id_stall_out(id_stall_out),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .id_ex_valid(id_ex_valid), .id_ex_cond(id_ex_cond), .id_ex_class(id_ex_class),
      .id_ex_opcode(id_ex_opcode), .id_ex_set_flags(id_ex_set_flags),
      .id_ex_rn_val(id_ex_rn_val), .id_ex_op2_val(id_ex_op2_val),
      .id_ex_shift_type(id_ex_shift_type), .id_ex_shift_amt(id_ex_shift_amt),
      .id_ex_rd(id_ex_rd), .id_ex_is_load(id_ex_is_load), .id_ex_is_store(id_ex_is_store),
      .id_ex_wb_base(id_ex_wb_base), .id_ex_wb_val(id_ex_wb_val),
      .id_ex_branch_target(id_ex_branch_target), .id_ex_pc(id_ex_pc)
   );

   typedef struct {
      logic        valid, stall, ld, st, wb;
      logic [1:0]  cls, sht;
      logic [4:0]  sha;
      logic [3:0]  rd;
      logic [31:0] rn, op2, wbv, tgt, pc;
      logic        m_op2, m_rd, m_rn, m_tgt, m_mem, m_sh;
   } uop_t;

   uop_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror_imm(input logic [7:0] imm, input logic [3:0] rot);
      logic [31:0] v;
      v = {24'd0, imm};
      for (int i = 0; i < 2 * int'(rot); i++) v = {v[0], v[31:1]};
      return v;
   endfunction

   // Expected uop stream for one instruction, straight from the ISA rules.
   task automatic build(input logic [31:0] ins, input logic [31:0] pc);
      uop_t u, w;
      int idx[$];
      int n, off;
      logic [31:0] base, lowest;
      u = '{default: 0};
      u.pc = pc;
      exp_q.delete();
      if (ins[31:28] == 4'hF || ins[27:26] == 2'b11) begin
         exp_q.push_back(u);
      end else if (ins[27:26] == 2'b00) begin
         u.valid = 1; u.cls = 0; u.rd = ins[15:12]; u.m_rd = 1; u.m_op2 = 1; u.m_mem = 1;
         if (ins[25]) u.op2 = ror_imm(ins[7:0], ins[11:8]);
         else begin
            u.op2 = regs[ins[3:0]]; u.m_sh = 1; u.sht = ins[6:5]; u.sha = ins[11:7];
         end
         exp_q.push_back(u);
      end else if (ins[27:26] == 2'b01) begin
         u.valid = 1; u.cls = 1; u.m_mem = 1; u.ld = ins[20]; u.st = !ins[20];
         exp_q.push_back(u);
      end else if (ins[25]) begin
         off = {{8{ins[23]}}, ins[23:0]};
         u.valid = 1; u.cls = 2; u.m_tgt = 1; u.tgt = pc + 32'd8 + 32'(off * 4);
         if (ins[24]) begin
            u.m_rd = 1; u.rd = 14; u.m_op2 = 1; u.op2 = pc + 32'd4;
         end
         exp_q.push_back(u);
      end else begin
         for (int i = 0; i < 16; i++) if (ins[i]) idx.push_back(i);
         n = idx.size();
         if (n == 0) exp_q.push_back(u);
         base = regs[ins[19:16]];
         lowest = ins[23] ? base + (ins[24] ? 32'd4 : 32'd0)
                          : base - 32'(4 * n) + (ins[24] ? 32'd0 : 32'd4);
         for (int k = 0; k < n; k++) begin
            w = u;
            w.valid = 1; w.cls = 3; w.m_rn = 1; w.m_rd = 1; w.m_mem = 1;
            w.rn = lowest + 32'(4 * k); w.rd = 4'(idx[k]);
            w.ld = ins[20]; w.st = !ins[20];
            w.stall = (k < n - 1);
            w.wb = ins[21] && (k == n - 1);
            w.wbv = ins[23] ? base + 32'(4 * n) : base - 32'(4 * n);
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic check_uop(input string tag, input uop_t u);
      chk({tag, ".valid"}, 32'(id_ex_valid), 32'(u.valid));
      chk({tag, ".wb_base"}, 32'(id_ex_wb_base), 32'(u.wb));
      if (u.valid) begin
         chk({tag, ".class"}, 32'(id_ex_class), 32'(u.cls));
         chk({tag, ".pc"}, id_ex_pc, u.pc);
         if (u.m_op2) chk({tag, ".op2"}, id_ex_op2_val, u.op2);
         if (u.m_rd)  chk({tag, ".rd"}, 32'(id_ex_rd), 32'(u.rd));
         if (u.m_rn)  chk({tag, ".rn_val"}, id_ex_rn_val, u.rn);
         if (u.m_tgt) chk({tag, ".target"}, id_ex_branch_target, u.tgt);
         if (u.m_mem) begin
            chk({tag, ".is_load"}, 32'(id_ex_is_load), 32'(u.ld));
            chk({tag, ".is_store"}, 32'(id_ex_is_store), 32'(u.st));
         end
         if (u.m_sh) begin
            chk({tag, ".shift_type"}, 32'(id_ex_shift_type), 32'(u.sht));
            chk({tag, ".shift_amt"}, 32'(id_ex_shift_amt), 32'(u.sha));
         end
         if (u.wb) chk({tag, ".wb_val"}, id_ex_wb_val, u.wbv);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rand_stall);
      build(ins, pc);
      @(negedge clk);
      if_id_instruction = ins; if_id_pc = pc; if_id_pc_plus_4 = pc + 32'd4;
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k > 0 && rand_stall && $urandom_range(3) == 0) begin
            @(negedge clk); stall_in = 1'b1; #1;
            chk({tag, ".stall_hold"}, 32'(id_stall_out), 32'd1);
            @(posedge clk); #1;
            check_uop({tag, ".held"}, exp_q[k-1]);
            stall_in = 1'b0;
         end
         if (k > 0) @(negedge clk);
         #1;
         chk({tag, ".stall_out"}, 32'(id_stall_out), 32'(exp_q[k].stall));
         chk({tag, ".ra1"}, 32'(rf_ra1), 32'(ins[19:16]));
         @(posedge clk); #1;
         check_uop(tag, exp_q[k]);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [3:0]  cond;
      logic [31:0] r;
      logic [15:0] list;
      cond = 4'($urandom_range(14));
      r = $urandom;
      list = ($urandom_range(3) == 0) ? 16'(1 << $urandom_range(15))
                                      : 16'($urandom) & 16'($urandom);
      case ($urandom_range(6))
         0:       return {cond, 3'b001, r[24:0]};
         1:       return {cond, 3'b000, r[24:5], 1'b0, r[3:0]};
         2:       return {cond, 3'b101, r[24:0]};
         3:       return {cond, 2'b01, r[25:0]};
         4, 5:    return {cond, 3'b100, r[24:23], 1'b0, r[21:16], list};
         default: return r[0] ? {4'hF, r[27:0]} : {cond, 2'b11, r[25:0]};
      endcase
   endfunction

   function automatic logic any_id_ex();
      return |{id_ex_valid, id_ex_cond, id_ex_class, id_ex_opcode, id_ex_set_flags,
               id_ex_rn_val, id_ex_op2_val, id_ex_shift_type, id_ex_shift_amt, id_ex_rd,
               id_ex_is_load, id_ex_is_store, id_ex_wb_base, id_ex_wb_val,
               id_ex_branch_target, id_ex_pc};
   endfunction

   initial begin
      rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
      if_id_instruction = 32'hF000_0000; if_id_pc = '0; if_id_pc_plus_4 = 32'd4;
      for (int r = 0; r < 16; r++) regs[r] = 32'h1111_1111 * r;
      #2;
      chk("reset.id_ex_zero", 32'(any_id_ex()), 32'd0);
      chk("reset.stall_out", 32'(id_stall_out), 32'd0);
      @(negedge clk); rst = 1'b0;

      run("mov_imm", 32'hE3A0_10FF, 32'h40, 1'b0);
      chk("mov_imm.const_op2", id_ex_op2_val, 32'h0000_00FF);
      run("mov_rot", 32'hE3A0_14FF, 32'h44, 1'b0);
      chk("mov_rot.const_op2", id_ex_op2_val, 32'hFF00_0000);
      run("bl", 32'hEBFF_FFFE, 32'h100, 1'b0);
      chk("bl.const_target", id_ex_branch_target, 32'h100);
      chk("bl.const_op2", id_ex_op2_val, 32'h104);

      regs[0] = 32'h1000;
      run("ldmia", 32'hE8B0_000E, 32'h200, 1'b0);
      chk("ldmia.const_wb_val", id_ex_wb_val, 32'h100C);

      // Flush landing on the second uop of the same LDM.
      @(negedge clk);
      if_id_instruction = 32'hE8B0_000E; if_id_pc = 32'h200; if_id_pc_plus_4 = 32'h204;
      @(posedge clk); #1;
      chk("flush.first_rn", id_ex_rn_val, 32'h1000);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      chk("flush.valid", 32'(id_ex_valid), 32'd0);
      chk("flush.wb_base", 32'(id_ex_wb_base), 32'd0);
      @(negedge clk); flush = 1'b0; if_id_instruction = 32'hE3A0_10FF; #1;
      chk("flush.stall_idle", 32'(id_stall_out), 32'd0);
      @(posedge clk); #1;
      chk("flush.resume_class", 32'(id_ex_class), 32'd0);
      chk("flush.resume_op2", id_ex_op2_val, 32'h0000_00FF);

      // Hazard hold: IF/ID changes underneath but ID/EX must not move.
      @(negedge clk); stall_in = 1'b1; if_id_instruction = 32'hE3A0_14FF;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall.stall_out", 32'(id_stall_out), 32'd1);
         @(posedge clk); #1;
         chk("stall.op2_held", id_ex_op2_val, 32'h0000_00FF);
         chk("stall.valid_held", 32'(id_ex_valid), 32'd1);
         @(negedge clk);
      end
      stall_in = 1'b0;
      @(posedge clk); #1;
      chk("stall.release_op2", id_ex_op2_val, 32'hFF00_0000);

      // Asynchronous reset in the middle of a sequence.
      @(negedge clk); if_id_instruction = 32'hE8B0_000E;
      @(posedge clk); #1;
      chk("rstseq.first_valid", 32'(id_ex_valid), 32'd1);
      #2; rst = 1'b1; #1;
      chk("rstseq.id_ex_zero", 32'(any_id_ex()), 32'd0);
      chk("rstseq.stall_out", 32'(id_stall_out), 32'd0);
      @(negedge clk); rst = 1'b0; if_id_instruction = 32'hF000_0000;
      @(posedge clk); #1;
      chk("rstseq.no_uop", 32'(id_ex_valid), 32'd0);
      chk("rstseq.no_wb", 32'(id_ex_wb_base), 32'd0);

      for (int t = 0; t < 80; t++) begin
         for (int r = 0; r < 16; r++) regs[r] = $urandom;
         run("rand", rand_instr(), {$urandom_range(32'h3FFF_FFFF), 2'b00}, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, instruction and operand width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall_in  in  1  hazard hold of ID/EX
- flush  in  1  branch taken; squash ID/EX
- if_id_instruction  in  32  fetched word
- if_id_pc  in  32  PC of fetched word
- if_id_pc_plus_4  in  32  PC+4 of fetched word
- id_stall_out  out  1  hold fetch and IF/ID (comb)
- rf_ra1, rf_ra2  out  4 each  register-file read addresses (comb)
- rf_rd1, rf_rd2  in  32 each  register-file read data
- id_ex_valid  out  1  ID/EX holds a live op
- id_ex_cond  out  4  condition field
- id_ex_class  out  2  0=DP, 1=LDR/STR, 2=branch, 3=block-transfer uop
- id_ex_opcode  out  4  DP opcode
- id_ex_set_flags  out  1  S bit
- id_ex_rn_val  out  32  first operand, or memory address for class 3
- id_ex_op2_val  out  32  rotated immediate or rf_rd2
- id_ex_shift_type  out  2  register-operand shift type
- id_ex_shift_amt  out  5  register-operand shift amount
- id_ex_rd  out  4  destination register
- id_ex_is_load  out  1  load
- id_ex_is_store  out  1  store
- id_ex_wb_base  out  1  write id_ex_wb_val to base register
- id_ex_wb_val  out  32  new base value
- id_ex_branch_target  out  32  branch target
- id_ex_pc  out  32  instruction PC

Function
REQ-004 Class decoding SHALL use bits [27:25]:
- 00x: DP
- 01x: LDR/STR
- 101: branch
- 100: LDM/STM
- anything else, or cond=1111: bubble (id_ex_valid=0).
REQ-005 A DP immediate (bit25=1) SHALL produce op2 = imm8 rotated right by 2*rot[11:8], modulo 32; rotation 0 passes imm8 unchanged.
REQ-006 A DP register operand SHALL produce op2=rf_rd2 with rf_ra2=instr[3:0], shift_type=[6:5], shift_amt=[11:7].
REQ-007 rf_ra1 SHALL equal instr[19:16] in all classes.
REQ-008 Branch target SHALL be if_id_pc + 8 + (sign-extended imm24 << 2), computed mod 2^32.
REQ-009 BL (bit24=1) SHALL set rd=14 and op2_val=if_id_pc_plus_4.
REQ-010 For LDR/STR: is_load=bit20 and is_store=!bit20; address arithmetic is left to execute.
REQ-011 LDM/STM SHALL be sequenced by an FSM with states IDLE and SEQ.
REQ-012 The register list SHALL be emitted one uop per cycle, lowest register first; n = popcount(list[15:0]).
REQ-013 The start address SHALL be, by P/U:
- IA: Rn
- IB: Rn+4
- DA: Rn-4n+4
- DB: Rn-4n
Uop k SHALL carry id_ex_rn_val = start+4k.
REQ-014 Rn SHALL be latched on the first uop and held for the whole sequence.
REQ-015 The first uop SHALL issue in IDLE.
- n>1: id_stall_out=1 that cycle; next state SEQ.
- n=1: single uop; remain IDLE.
REQ-016 In SEQ, id_stall_out SHALL be 1 on every uop except the last; after the last uop the FSM SHALL return to IDLE.
REQ-017 An LDM/STM of n registers SHALL occupy exactly n issue cycles.
REQ-018 With W=1, wb_base=1 and wb_val=Rn±4n on the last uop only.
REQ-019 An empty register list SHALL produce a bubble with no stall and no writeback.
REQ-020 When stall_in=1 and flush=0, ID/EX and the FSM SHALL hold, and id_stall_out SHALL be 1.
REQ-021 When flush=1, on the next edge id_ex_valid=0 and FSM=IDLE, overriding stall_in and any sequence in progress.
REQ-022 Whenever the FSM is IDLE and the stage is not held or flushed, ID/EX SHALL load every cycle, with one-cycle latency IF/ID to ID/EX.

Reset
REQ-023 rst SHALL asynchronously force every id_ex_* output to 0 and the FSM to IDLE.
REQ-024 While rst=1, id_stall_out SHALL be 0.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence with no further uops or writeback.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- E3A010FF (MOV R1,#255) -> class 0, op2=0x000000FF, rd=1, valid=1 one cycle later.
- E3A014FF (rot=4) -> op2=0xFF000000.
- EBFFFFFE at pc 0x100 -> target 0x100, rd=14, op2=0x104.
- E8B0000E (LDMIA R0!,{R1-R3}), R0=0x1000 -> 3 uops at 0x1000/0x1004/0x1008, id_stall_out high for 2 cycles, wb_val=0x100C on the third uop only.
- flush on the second uop of that LDM -> valid=0 next edge, FSM IDLE, id_stall_out 0, no writeback.
- stall_in held 3 cycles during DP -> ID/EX unchanged throughout; rst pulse mid-sequence -> all outputs 0 immediately.
